// File: rtl/demux4_reg.sv
// demux4_reg: registered 1-to-4 demultiplexer with valid/ready handshakes.
//
// One producer fans out to four consumers (a, b, c, d). Each accepted input
// word is steered by in_sel into that channel's 1-deep holding register and
// appears on the channel one cycle after acceptance. Each channel stalls
// independently; a full, stalled channel blocks only input words aimed at it.
//
// Parameters:
//   WIDTH      data width of the input and of each output channel
//   CNT_WIDTH  width of the per-channel delivery counters
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      input handshake (in_ready = target channel free)
//   in_data, in_sel        input word and destination (00=a 01=b 10=c 11=d)
//   k_valid/k_ready        channel k handshake (k = a, b, c, d)
//   k_data                 channel k holding register contents
//   k_cnt                  words delivered on channel k, wrapping
//
// Optional feature, macro DEMUX4_CNT_EN: when defined, the k_cnt ports and
// the counting logic exist; when undefined they are absent entirely.

module demux4_reg #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  output logic                 a_valid,
  output logic                 b_valid,
  output logic                 c_valid,
  output logic                 d_valid,
  input  logic                 a_ready,
  input  logic                 b_ready,
  input  logic                 c_ready,
  input  logic                 d_ready,
`ifdef DEMUX4_CNT_EN
  output logic [CNT_WIDTH-1:0] a_cnt,
  output logic [CNT_WIDTH-1:0] b_cnt,
  output logic [CNT_WIDTH-1:0] c_cnt,
  output logic [CNT_WIDTH-1:0] d_cnt,
`endif
  output logic [WIDTH-1:0]     a_data,
  output logic [WIDTH-1:0]     b_data,
  output logic [WIDTH-1:0]     c_data,
  output logic [WIDTH-1:0]     d_data
);

  if (WIDTH < 1) begin : g_bad_width
    $error("demux4_reg: WIDTH must be at least 1");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("demux4_reg: CNT_WIDTH must be at least 1");
  end

  logic [3:0]       rdy_p0;
  logic [3:0]       free_p0;
  logic [3:0]       load_p0;
  logic [3:0]       take_p0;
  logic [3:0]       vld_p1;
  logic [WIDTH-1:0] dat_p1 [4];

  // ---- stage p0: combinational handshake decode ----
  assign rdy_p0  = {d_ready, c_ready, b_ready, a_ready};
  // A channel can take a new word if empty or if its current word leaves
  // on this same edge, which gives 1 word/cycle per channel.
  assign free_p0 = ~vld_p1 | rdy_p0;
  // in_valid is deliberately kept out of in_ready so there is no path from
  // in_valid to any output.
  assign in_ready = ~rst & free_p0[in_sel];
  assign load_p0  = {4{in_valid & in_ready}} & (4'b0001 << in_sel);
  assign take_p0  = vld_p1 & rdy_p0;

  // ---- stage p1: per-channel holding registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= '0;
      for (int k = 0; k < 4; k++) begin
        dat_p1[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load_p0[k]) begin
          vld_p1[k] <= 1'b1;
          dat_p1[k] <= in_data;
        end else if (take_p0[k]) begin
          // Data is left as is after delivery; only the valid drops.
          vld_p1[k] <= 1'b0;
        end
      end
    end
  end

  assign a_valid = vld_p1[0];
  assign b_valid = vld_p1[1];
  assign c_valid = vld_p1[2];
  assign d_valid = vld_p1[3];
  assign a_data  = dat_p1[0];
  assign b_data  = dat_p1[1];
  assign c_data  = dat_p1[2];
  assign d_data  = dat_p1[3];

`ifdef DEMUX4_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_p1 [4];

  // ---- stage p1: delivery counters, wrap naturally at 2^CNT_WIDTH ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        cnt_p1[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (take_p0[k]) begin
          cnt_p1[k] <= cnt_p1[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign a_cnt = cnt_p1[0];
  assign b_cnt = cnt_p1[1];
  assign c_cnt = cnt_p1[2];
  assign d_cnt = cnt_p1[3];
`endif

endmodule

// File: tb/tb_demux4_reg.sv
// Testbench for demux4_reg. The reference model treats each channel as a
// one-entry queue: accepted words are pushed to the queue of their
// destination, and a monitor pops and compares each delivered word.
module tb_demux4_reg;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          a_valid, b_valid, c_valid, d_valid;
  logic          a_ready, b_ready, c_ready, d_ready;
  logic [W-1:0]  a_data, b_data, c_data, d_data;
`ifdef DEMUX4_CNT_EN
  logic [CW-1:0] a_cnt, b_cnt, c_cnt, d_cnt;
`endif

  always #5 clk = ~clk;

  demux4_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
`ifdef DEMUX4_CNT_EN
    .a_cnt(a_cnt), .b_cnt(b_cnt), .c_cnt(c_cnt), .d_cnt(d_cnt),
`endif
    .a_data(a_data), .b_data(b_data), .c_data(c_data), .d_data(d_data)
  );

  logic [3:0]   vvec;
  logic [3:0]   rvec;
  logic [W-1:0] dvec [4];
  assign vvec    = {d_valid, c_valid, b_valid, a_valid};
  assign rvec    = {d_ready, c_ready, b_ready, a_ready};
  assign dvec[0] = a_data;
  assign dvec[1] = b_data;
  assign dvec[2] = c_data;
  assign dvec[3] = d_data;
`ifdef DEMUX4_CNT_EN
  logic [CW-1:0] cvec [4];
  assign cvec[0] = a_cnt;
  assign cvec[1] = b_cnt;
  assign cvec[2] = c_cnt;
  assign cvec[3] = d_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q [4][$];
  int unsigned  exp_cnt [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge: applies inputs, predicts in_ready at the
  // falling edge, then updates the model for what the next edge does.
  task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] dat,
                      input logic [3:0] r, input logic rs, output logic acc);
    logic exp_rdy;
    in_valid = v;
    in_sel   = s;
    in_data  = dat;
    {d_ready, c_ready, b_ready, a_ready} = r;
    rst      = rs;
    @(negedge clk);
    exp_rdy = !rs && (q[s].size() == 0 || r[s]);
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    if (rs) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        exp_cnt[k] = 0;
      end
    end else if (acc) begin
      q[s].push_back(dat);
    end
  endtask

  task automatic go(input logic v, input logic [1:0] s, input logic [W-1:0] dat,
                    input logic [3:0] r, input logic rs);
    logic acc;
    step(v, s, dat, r, rs, acc);
  endtask

  // Monitor: compares channel outputs with the model every cycle and pops a
  // word whenever the channel presents it to a ready consumer.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("valid[%0d]", k), {63'd0, vvec[k]}, {63'd0, (q[k].size() != 0)});
        if (vvec[k] && q[k].size() != 0) begin
          check($sformatf("data[%0d]", k), {32'd0, dvec[k]}, {32'd0, q[k][0]});
        end
`ifdef DEMUX4_CNT_EN
        check($sformatf("cnt[%0d]", k), {60'd0, cvec[k]}, 64'(exp_cnt[k] % (1 << CW)));
`endif
        if (!rst && vvec[k] && rvec[k] && q[k].size() != 0) begin
          void'(q[k].pop_front());
          exp_cnt[k]++;
        end
      end
    end
  end

  initial begin
    logic         acc;
    logic         last_v;
    logic         last_acc;
    logic [1:0]   last_s;
    logic [W-1:0] last_d;
    logic [1:0]   s;
    logic [W-1:0] d;
    logic         v;

    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = '0;
    {d_ready, c_ready, b_ready, a_ready} = 4'h0;
    @(posedge clk);
    #1;

    // Reset with a pending input: in_ready must stay low.
    go(1'b1, 2'd2, 32'h5555_AAAA, 4'h0, 1'b1);
    go(1'b1, 2'd2, 32'h5555_AAAA, 4'h0, 1'b1);
    for (int k = 0; k < 4; k++) check($sformatf("rst_data[%0d]", k), {32'd0, dvec[k]}, 64'd0);

    // Single route to channel c, then drain.
    go(1'b1, 2'd2, 32'hDEADBEEF, 4'h0, 1'b0);
    go(1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
    go(1'b0, 2'd0, 32'h0, 4'b0100, 1'b0);
    go(1'b0, 2'd0, 32'h0, 4'h0, 1'b0);

    // Backpressure isolation between b and d.
    go(1'b1, 2'd1, 32'h11, 4'h0, 1'b0);
    go(1'b1, 2'd1, 32'h22, 4'h0, 1'b0);
    go(1'b1, 2'd3, 32'h22, 4'h0, 1'b0);
    check("hold_b_data", {32'd0, b_data}, 64'h11);
    check("route_d_data", {32'd0, d_data}, 64'h22);
    go(1'b0, 2'd0, 32'h0, 4'hF, 1'b0);

    // Back-to-back streaming into a.
    for (int i = 1; i <= 4; i++) go(1'b1, 2'd0, W'(i), 4'b0001, 1'b0);
    go(1'b0, 2'd0, 32'h0, 4'b0001, 1'b0);

    // All channels full and stalled, then reset mid-operation.
    for (int k = 0; k < 4; k++) go(1'b1, 2'(k), $urandom, 4'h0, 1'b0);
    go(1'b1, 2'd0, 32'h77, 4'h0, 1'b1);
    for (int k = 0; k < 4; k++) check($sformatf("mid_rst_data[%0d]", k), {32'd0, dvec[k]}, 64'd0);
    go(1'b1, 2'd1, 32'hABCD, 4'h0, 1'b0);
    go(1'b0, 2'd0, 32'h0, 4'b0010, 1'b0);
    go(1'b0, 2'd0, 32'h0, 4'h0, 1'b0);

    // 17 deliveries on d from a clean state; a CW-bit counter wraps to 1.
    go(1'b0, 2'd0, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 17; i++) go(1'b1, 2'd3, $urandom, 4'b1000, 1'b0);
    go(1'b0, 2'd0, 32'h0, 4'b1000, 1'b0);
`ifdef DEMUX4_CNT_EN
    check("d_cnt_wrap", {60'd0, d_cnt}, 64'd1);
    check("a_cnt_idle", {60'd0, a_cnt}, 64'd0);
    check("b_cnt_idle", {60'd0, b_cnt}, 64'd0);
    check("c_cnt_idle", {60'd0, c_cnt}, 64'd0);
`endif

    // Randomized traffic; a stalled producer holds its word.
    last_v = 1'b0; last_acc = 1'b0; last_s = '0; last_d = '0;
    for (int i = 0; i < 2000; i++) begin
      if (last_v && !last_acc) begin
        v = 1'b1; s = last_s; d = last_d;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = $urandom;
      end
      step(v, s, d, 4'($urandom), ($urandom_range(0, 199) == 0), acc);
      last_v = v; last_s = s; last_d = d; last_acc = acc || rst;
    end
    go(1'b0, 2'd0, 32'h0, 4'hF, 1'b0);
    go(1'b0, 2'd0, 32'h0, 4'hF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux4_reg.md
Name: demux4_reg

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshakes; the distribution counterpart of mux4.
- Steers one input word to one of four output channels (a, b, c, d) selected per transfer by `in_sel`.
- Each output channel has its own 1-deep holding register, so a stalled consumer blocks only its own channel.
- Used where one producer (e.g. a writeback or bus response path) fans out to four consumers that may stall independently.

Parameters:
- WIDTH, 32, data width of input and each output channel.
- CNT_WIDTH, 16, width of per-channel delivery counters (used only with DEMUX4_CNT_EN).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts the input word this cycle
- in_data  input  WIDTH  input word
- in_sel  input  2  destination: 00=a, 01=b, 10=c, 11=d
- a_valid, b_valid, c_valid, d_valid  output  1 each  channel holding register full
- a_ready, b_ready, c_ready, d_ready  input  1 each  channel consumer accepts
- a_data, b_data, c_data, d_data  output  WIDTH each  channel holding register contents
- a_cnt, b_cnt, c_cnt, d_cnt  output  CNT_WIDTH each  delivered-word counters (DEMUX4_CNT_EN only)

Behaviour:
- One clock `clk`. Reset is synchronous and active-high on `rst`.
- Reset values:
  - all *_valid = 0
  - all *_data = 0
  - all *_cnt = 0
- Channel k state: `vk` (valid) and `dk` (data).
- Free condition: `free_k = !vk | k_ready`.
- `in_ready = free[in_sel]`. This is combinational from `in_sel`, the target channel's valid and the target channel's ready.
- `in_ready` is 0 while `rst` = 1.
- Input transfer: `in_valid & in_ready` at a rising edge. On that edge, channel `in_sel` loads `dk <= in_data` and sets `vk <= 1`.
- Output transfer: `vk & k_ready` at a rising edge.
  - If the channel is not loaded on the same edge, it clears `vk`.
  - `dk` keeps its value.
- Simultaneous output transfer and input load on the same channel: `vk` stays 1 and `dk` takes the new word. Full throughput is 1 word/cycle per channel.
- Latency: an accepted word appears on the selected channel's valid/data the cycle after acceptance.
- Channels not selected by `in_sel` are unaffected by the input transfer and drain independently.
- Stability: while `vk = 1` and `k_ready = 0`, `dk` and `vk` hold unchanged.
- Backpressure:
  - If the target channel is full and its ready is low, `in_ready = 0` and nothing is loaded.
  - Producers must hold `in_data`/`in_sel` stable while `in_valid & !in_ready`.
  - The block itself tolerates `in_sel` changing; it re-evaluates `in_ready` each cycle.
- `in_valid = 0`: no channel is loaded, regardless of `in_ready`.
- Reset mid-operation: all held words are discarded, valids drop to 0 on the reset edge, and counters clear.
- No combinational path from `in_valid` to any output. `k_ready` reaches `in_ready` combinationally only.

Optional Feature:
- Macro: DEMUX4_CNT_EN.
- Defined:
  - Counters `a_cnt`…`d_cnt` are present.
  - Counter k increments by 1 on each output transfer of channel k.
  - Counters wrap from `2^CNT_WIDTH-1` to 0.
  - Reset clears all counters.
- Not defined: the counter ports and counter logic are omitted entirely; there is no port stub.

Test Plan:
- Reset then idle: assert `rst` for 2 cycles with `in_valid=1`, `in_sel=2` → `in_ready=0` during reset; after reset all *_valid=0 and all *_data=0.
- Single route: `in_data=32'hDEADBEEF`, `in_sel=2'b10`, `in_valid=1` for 1 cycle with `c_ready=0` → next cycle `c_valid=1`, `c_data=DEADBEEF`, and a/b/d_valid=0. Then `c_ready=1` for 1 cycle → `c_valid=0`.
- Backpressure isolation:
  - Fill channel b (`in_data=0x11`, `b_ready=0`), then present `in_sel=01`, `in_data=0x22` → `in_ready=0` and `b_data` stays 0x11.
  - Switch `in_sel` to 11 → `in_ready=1`; `d_data=0x22` next cycle.
- Back-to-back streaming: `a_ready=1` held, send 0x1,0x2,0x3,0x4 to `in_sel=00` on consecutive cycles → `in_ready=1` every cycle; `a_data` shows 0x1..0x4 on the following 4 cycles with `a_valid=1` throughout.
- Reset mid-operation: all four channels full with consumers stalled, assert `rst` 1 cycle → all *_valid=0 next cycle; the new word accepted immediately after reset is delivered correctly.
- Counters (DEMUX4_CNT_EN, CNT_WIDTH=4):
  - Deliver 17 words to channel d → `d_cnt=1` (wrapped); other counters stay 0.
  - Rebuild without the macro → bench compiles without the *_cnt ports.
